// File: rtl/vga_timing.sv
// vga_timing: raster counters, sync/blank decode and the single registered
// output stage for the VGA connector. Everything that leaves this block
// (RGB, hsync, vsync, blank) is loaded on the same pix_en edge from the same
// counter value, so it all stays in one pixel slot.
//
// pix_en is a qualifier, not a handshake: there is no back-pressure. On a clk
// edge with pix_en=1 the raster advances one slot and the output stage loads.
// With pix_en=0 every register holds, except frame_start, which is a
// one-clk pulse and always clears on the following edge.
module vga_timing #(
  parameter int unsigned H_VIS    = 1024,
  parameter int unsigned H_FP     = 24,
  parameter int unsigned H_SYNC   = 136,
  parameter int unsigned H_BP     = 160,
  parameter int unsigned V_VIS    = 768,
  parameter int unsigned V_FP     = 3,
  parameter int unsigned V_SYNC   = 6,
  parameter int unsigned V_BP     = 29,
  parameter logic        SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  output logic [11:0] hcounter,
  output logic [10:0] vcounter,
  input  logic [3:0]  color,
  output logic        vga_r,
  output logic        vga_g,
  output logic        vga_b,
  output logic        hsync,
  output logic        vsync,
  output logic        blank,
  output logic        frame_start
);

  localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  // Decode constants sized to the counters they are compared against.
  localparam logic [11:0] H_LAST   = 12'(H_TOT - 1);
  localparam logic [11:0] H_VIS_W  = 12'(H_VIS);
  localparam logic [11:0] H_SS     = 12'(H_VIS + H_FP);
  localparam logic [11:0] H_SE     = 12'(H_VIS + H_FP + H_SYNC);
  localparam logic [10:0] V_LAST   = 11'(V_TOT - 1);
  localparam logic [10:0] V_VIS_W  = 11'(V_VIS);
  localparam logic [10:0] V_SS     = 11'(V_VIS + V_FP);
  localparam logic [10:0] V_SE     = 11'(V_VIS + V_FP + V_SYNC);

  logic [11:0] r_hcount;
  logic [10:0] r_vcount;
  logic [2:0]  r_rgb;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_blank;
  logic        r_frame_start;

  logic [11:0] w_h_next;
  logic [10:0] w_v_next;
  logic        w_h_last;
  logic        w_v_last;
  logic        w_hs_act;
  logic        w_vs_act;
  logic        w_visible;
  logic [2:0]  w_rgb;

  // Next raster position and the per-slot decode of the current position.
  // Line wrap and frame wrap are decided together so (0, V_TOT) never exists.
  always_comb begin
    w_h_last  = (r_hcount == H_LAST);
    w_v_last  = (r_vcount == V_LAST);
    w_h_next  = w_h_last ? 12'd0 : r_hcount + 12'd1;
    w_v_next  = r_vcount;
    if (w_h_last) begin
      w_v_next = w_v_last ? 11'd0 : r_vcount + 11'd1;
    end
    w_hs_act  = (r_hcount >= H_SS) && (r_hcount < H_SE);
    w_vs_act  = (r_vcount >= V_SS) && (r_vcount < V_SE);
    w_visible = (r_hcount < H_VIS_W) && (r_vcount < V_VIS_W);
    // Palette: bit 3 enables the colour, bits 2:0 are {r,g,b}.
    w_rgb     = (w_visible && color[3]) ? color[2:0] : 3'b000;
  end

  // Raster counters advance one slot per enabled edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hcount <= 12'd0;
      r_vcount <= 11'd0;
    end else if (pix_en) begin
      r_hcount <= w_h_next;
      r_vcount <= w_v_next;
    end
  end

  // Output stage: RGB, syncs and blank load together from the same slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rgb   <= 3'b000;
      r_hsync <= ~SYNC_POL;
      r_vsync <= ~SYNC_POL;
      r_blank <= 1'b1;
    end else if (pix_en) begin
      r_rgb   <= w_rgb;
      r_hsync <= w_hs_act ? SYNC_POL : ~SYNC_POL;
      r_vsync <= w_vs_act ? SYNC_POL : ~SYNC_POL;
      r_blank <= ~w_visible;
    end
  end

  // Frame tick: set on the edge that loads (0,0) after the last slot, and
  // dropped on the very next clk edge whatever pix_en does.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= pix_en && w_h_last && w_v_last;
    end
  end

  assign hcounter    = r_hcount;
  assign vcounter    = r_vcount;
  assign vga_r       = r_rgb[2];
  assign vga_g       = r_rgb[1];
  assign vga_b       = r_rgb[0];
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign blank       = r_blank;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: directed bench for vga_timing using a shrunk raster
// (24 x 13 slots per frame) so whole frames fit in a short run. A second
// instance with SYNC_POL=1 shares every input and must show inverted syncs.
module tb_vga_timing;

  // Shrunk raster: H_TOT = 16+2+3+3 = 24, V_TOT = 8+1+2+2 = 13, frame = 312.
  localparam int H_VIS  = 16;
  localparam int H_FP   = 2;
  localparam int H_SYNC = 3;
  localparam int H_BP   = 3;
  localparam int V_VIS  = 8;
  localparam int V_FP   = 1;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 2;
  localparam int H_TOT  = 24;
  localparam int V_TOT  = 13;

  // ---------------- clock / reset block ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pix_en = 1'b0;
  logic [3:0]  color = 4'b0000;

  always #5 clk = ~clk;

  logic [11:0] hcounter, hcounter_p;
  logic [10:0] vcounter, vcounter_p;
  logic        vga_r, vga_g, vga_b, hsync, vsync, blank, frame_start;
  logic        vga_r_p, vga_g_p, vga_b_p, hsync_p, vsync_p, blank_p, frame_start_p;

  vga_timing #(
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SYNC_POL(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .hcounter(hcounter), .vcounter(vcounter), .color(color),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .hsync(hsync), .vsync(vsync), .blank(blank), .frame_start(frame_start)
  );

  vga_timing #(
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SYNC_POL(1'b1)
  ) dut_p (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .hcounter(hcounter_p), .vcounter(vcounter_p), .color(color),
    .vga_r(vga_r_p), .vga_g(vga_g_p), .vga_b(vga_b_p),
    .hsync(hsync_p), .vsync(vsync_p), .blank(blank_p), .frame_start(frame_start_p)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected state after the most recent edge.
  int         m_h = 0;
  int         m_v = 0;
  logic [2:0] m_rgb = 3'b000;
  logic       m_hs = 1'b1;
  logic       m_vs = 1'b1;
  logic       m_blank = 1'b1;
  logic       m_fs = 1'b0;

  // Trackers for pulse widths and frame period.
  int   cyc = 0;
  int   hs_run = 0, hs_last_run = 0;
  int   vs_run = 0, vs_last_run = 0;
  int   fs_count = 0, fs_last_cyc = -1, fs_period = 0, fs_first_cyc = -1, fs_double = 0;
  logic fs_prev = 1'b0;

  task automatic clear_trackers();
    cyc = 0;
    hs_run = 0; hs_last_run = 0;
    vs_run = 0; vs_last_run = 0;
    fs_count = 0; fs_last_cyc = -1; fs_period = 0; fs_first_cyc = -1; fs_double = 0;
    fs_prev = 1'b0;
  endtask

  // ---------------- driver ----------------
  // Apply inputs for one edge, advance the expected state, then compare.
  task automatic step(input logic t_rst, input logic t_en, input logic [3:0] t_color);
    logic vis;
    logic inv_hs, inv_vs;
    rst    = t_rst;
    pix_en = t_en;
    color  = t_color;
    if (t_rst) begin
      m_h = 0; m_v = 0; m_rgb = 3'b000;
      m_hs = 1'b1; m_vs = 1'b1; m_blank = 1'b1; m_fs = 1'b0;
    end else if (t_en) begin
      vis     = (m_h < H_VIS) && (m_v < V_VIS);
      m_rgb   = (vis && t_color[3]) ? t_color[2:0] : 3'b000;
      m_blank = !vis;
      m_hs    = !((m_h >= 18) && (m_h < 21));
      m_vs    = !((m_v >= 9) && (m_v < 11));
      m_fs    = (m_h == H_TOT - 1) && (m_v == V_TOT - 1);
      if (m_h == H_TOT - 1) begin
        m_h = 0;
        m_v = (m_v == V_TOT - 1) ? 0 : m_v + 1;
      end else begin
        m_h = m_h + 1;
      end
    end else begin
      m_fs = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
    inv_hs = !m_hs;
    inv_vs = !m_vs;
    check_val("hcounter", hcounter, m_h);
    check_val("vcounter", vcounter, m_v);
    check_val("rgb", {vga_r, vga_g, vga_b}, m_rgb);
    check_val("hsync", hsync, m_hs);
    check_val("vsync", vsync, m_vs);
    check_val("blank", blank, m_blank);
    check_val("frame_start", frame_start, m_fs);
    check_val("hsync_pol1", hsync_p, inv_hs);
    check_val("vsync_pol1", vsync_p, inv_vs);
    if (hsync == 1'b0) hs_run++;
    else begin if (hs_run > 0) hs_last_run = hs_run; hs_run = 0; end
    if (vsync == 1'b0) vs_run++;
    else begin if (vs_run > 0) vs_last_run = vs_run; vs_run = 0; end
    if (frame_start === 1'b1) begin
      fs_count++;
      if (fs_first_cyc < 0) fs_first_cyc = cyc;
      if (fs_last_cyc >= 0) fs_period = cyc - fs_last_cyc;
      fs_last_cyc = cyc;
      if (fs_prev) fs_double++;
    end
    fs_prev = frame_start;
  endtask

  logic [3:0] color_tab [6];

  // ---------------- stimulus + final report ----------------
  initial begin
    color_tab[0] = 4'b1100;
    color_tab[1] = 4'b0111;
    color_tab[2] = 4'b1111;
    color_tab[3] = 4'b1010;
    color_tab[4] = 4'b1011;
    color_tab[5] = 4'b1110;

    // Reset state, with pix_en both low and high.
    step(1'b1, 1'b0, 4'b1111);
    step(1'b1, 1'b1, 4'b1111);

    // Free run, pix_en held high: red for the first frame, then mixed colours.
    clear_trackers();
    for (int i = 0; i < 700; i++) begin
      step(1'b0, 1'b1, (i < 312) ? 4'b1100 : color_tab[i % 6]);
    end
    check_val("hsync_width", hs_last_run, 3);
    check_val("vsync_width", vs_last_run, 2 * H_TOT);
    check_val("frame_count_en1", fs_count, 2);
    check_val("frame_period_en1", fs_period, 312);
    check_val("frame_first_en1", fs_first_cyc, 312);
    check_val("frame_width_en1", fs_double, 0);

    // Directed palette/blank slots on a fresh raster (red held).
    step(1'b1, 1'b0, 4'b1100);
    for (int i = 0; i < 5 * H_TOT + 10; i++) step(1'b0, 1'b1, 4'b1100);
    check_val("at_h10", hcounter, 10);
    check_val("at_v5", vcounter, 5);
    step(1'b0, 1'b1, 4'b1100);
    check_val("red_visible", {vga_r, vga_g, vga_b, blank}, 4'b1000);
    step(1'b0, 1'b1, 4'b0111);
    check_val("dark_index", {vga_r, vga_g, vga_b, blank}, 4'b0000);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 4'b1100);
    check_val("at_h16", hcounter, 16);
    step(1'b0, 1'b1, 4'b1100);
    check_val("red_blanked", {vga_r, vga_g, vga_b, blank}, 4'b0001);

    // pix_en on every second cycle: holds on idle edges, period doubles.
    step(1'b1, 1'b0, 4'b0000);
    clear_trackers();
    for (int i = 0; i < 1300; i++) begin
      step(1'b0, (i % 2) == 0, color_tab[i % 6]);
    end
    check_val("frame_count_en2", fs_count, 2);
    check_val("frame_period_en2", fs_period, 624);
    check_val("frame_width_en2", fs_double, 0);

    // Reset mid-frame at (5,3) with pix_en high; no early frame tick after.
    step(1'b1, 1'b0, 4'b0000);
    for (int i = 0; i < 3 * H_TOT + 5; i++) step(1'b0, 1'b1, 4'b1111);
    check_val("pre_rst_h", hcounter, 5);
    check_val("pre_rst_v", vcounter, 3);
    step(1'b1, 1'b1, 4'b1111);
    check_val("rst_outputs", {hcounter, vcounter, vga_r, vga_g, vga_b, hsync, vsync, blank},
              {12'd0, 11'd0, 3'b000, 1'b1, 1'b1, 1'b1});
    clear_trackers();
    step(1'b0, 1'b0, 4'b1111);
    for (int i = 0; i < 320; i++) step(1'b0, 1'b1, 4'b1111);
    check_val("post_rst_frames", fs_count, 1);
    check_val("post_rst_first", fs_first_cyc, 313);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
